ov_7670_stream_gen: RTL and testbench

//   OV7670-style pixel stream transmitter (camera emulator): drives VSYNC/HREF/DATA[7:0]

---
 rtl/ov_7670_stream_gen.sv | 172 +++++++++++++++++
 tb/tb_ov_7670_stream_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ov_7670_stream_gen.sv
// OV7670-style camera emulator: emits VSYNC/HREF/DATA byte streams carrying RGB565 test
// patterns (high byte first) so the capture path can run without a real sensor.
module ov_7670_stream_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          H_BLANK   = 144,
    parameter int          VS_LINES  = 3,
    parameter int          V_BACK    = 17,
    parameter int          V_FRONT   = 10,
    parameter logic [15:0] SOLID_RGB = 16'hF800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int LP = 2 * H_ACTIVE + H_BLANK;
    localparam int CW = $clog2(LP);
    localparam logic [CW-1:0] COL_LAST = CW'(LP - 1);
    localparam logic [CW-1:0] HREF_END = CW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] col_r, col_s;
    logic [15:0]   line_r, line_s;
    logic [1:0]    pat_r, pat_s;
    logic          line_end_s, last_line_s, frame_end_s;
    logic          vsync_s, href_s, busy_s, done_s;
    logic [7:0]    data_s;
    logic [15:0]   pix_s;

    function automatic logic [15:0] lines_in(input state_t st);
        logic [15:0] n;
        case (st)
            S_VSYNC:  n = 16'(VS_LINES);
            S_VBACK:  n = 16'(V_BACK);
            S_ACTIVE: n = 16'(V_ACTIVE);
            S_VFRONT: n = 16'(V_FRONT);
            default:  n = 16'd1;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] pixel(input logic [1:0] pat, input logic [15:0] x,
                                          input logic [7:0] y);
        logic [2:0]  bar;
        logic [15:0] p;
        bar = 3'(({16'd0, x} * 32'd8) / 32'(H_ACTIVE));
        case (pat)
            2'd0: p = SOLID_RGB;
            2'd1: begin
                case (bar)
                    3'd0:    p = 16'hFFFF;
                    3'd1:    p = 16'hFFE0;
                    3'd2:    p = 16'h07FF;
                    3'd3:    p = 16'h07E0;
                    3'd4:    p = 16'hF81F;
                    3'd5:    p = 16'hF800;
                    3'd6:    p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            2'd2:    p = x;
            default: p = {y, x[7:0]};
        endcase
        return p;
    endfunction

    // Next-state/counter logic; outputs derived from the next position so they register in step with it
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        line_s      = line_r;
        pat_s       = pat_r;
        line_end_s  = (col_r == COL_LAST);
        last_line_s = (line_r == (lines_in(state_r) - 16'd1));
        frame_end_s = (state_r == S_VFRONT) && line_end_s && last_line_s;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_s = S_VSYNC;
                    col_s   = '0;
                    line_s  = 16'd0;
                    pat_s   = pattern_sel;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                if (line_end_s) begin
                    col_s = '0;
                    if (last_line_s) begin
                        line_s = 16'd0;
                        case (state_r)
                            S_VSYNC:  state_s = S_VBACK;
                            S_VBACK:  state_s = S_ACTIVE;
                            S_ACTIVE: state_s = S_VFRONT;
                            S_VFRONT: begin
                                if (enable) begin
                                    state_s = S_VSYNC;
                                    pat_s   = pattern_sel;
                                end else begin
                                    state_s = S_IDLE;
                                end
                            end
                            default:  state_s = S_IDLE;
                        endcase
                    end else begin
                        line_s = line_r + 16'd1;
                    end
                end else begin
                    col_s = col_r + CW'(1);
                end
            end
        endcase

        vsync_s = (state_s == S_VSYNC);
        href_s  = (state_s == S_ACTIVE) && (col_s < HREF_END);
        pix_s   = pixel(pat_s, 16'(col_s >> 1), line_s[7:0]);
        if (href_s) begin
            data_s = col_s[0] ? pix_s[7:0] : pix_s[15:8];
        end else begin
            data_s = 8'h00;
        end
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_VFRONT) && (col_s == COL_LAST) && (line_s == 16'(V_FRONT - 1));
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            col_r      <= '0;
            line_r     <= 16'd0;
            pat_r      <= 2'd0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            line_r     <= line_s;
            pat_r      <= pat_s;
            vsync      <= vsync_s;
            href       <= href_s;
            data       <= data_s;
            busy       <= busy_s;
            frame_done <= done_s;
            if (frame_end_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov_7670_stream_gen.sv
// Bench for ov_7670_stream_gen: frame-time reference model checked every cycle, plus
// hand-computed timing/byte expectations and random enable/pattern/reset stimulus.
module tb_ov_7670_stream_gen;

    localparam int HA = 8, VA = 4, HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int LP = 2 * HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LP;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [1:0]  pattern_sel;
    logic        vsync, href, busy, frame_done;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int checks = 0, errors = 0;

    ov_7670_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VS_LINES(VS), .V_BACK(VB),
        .V_FRONT(VF), .SOLID_RGB(16'hF800)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .vsync(vsync), .href(href), .data(data), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a frame is a run of FRAME cycles indexed by t
    bit          m_act = 1'b0;
    int          m_t = 0, m_pat = 0, cyc = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          last_rst = 1'b0;
    bit          cmp_en = 1'b0;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            last_rst = reset;
            if (reset) begin
                m_act = 1'b0; m_t = 0; m_cnt = 16'd0;
            end else if (!m_act) begin
                if (enable) begin
                    m_act = 1'b1; m_t = 0; m_pat = int'(pattern_sel);
                end
            end else if (m_t == FRAME - 1) begin
                m_cnt = m_cnt + 16'd1;
                if (enable) begin
                    m_t = 0; m_pat = int'(pattern_sel);
                end else begin
                    m_act = 1'b0;
                end
            end else begin
                m_t++;
            end
        end
    end

    // Compare process plus line capture
    logic [7:0] cap [4][16];
    int line_idx = 0, kb = 0, done_cnt = 0;
    int rises[$];
    bit prev_href = 1'b0, prev_vs = 1'b0;
    int ln, cl, al, px, e_pix;
    bit e_vs, e_href;
    logic [7:0] e_data;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                ln = m_t / LP; cl = m_t % LP; al = ln - (VS + VB); px = cl / 2;
                e_vs   = m_act && (ln < VS);
                e_href = m_act && (al >= 0) && (al < VA) && (cl < 2 * HA);
                case (m_pat)
                    0:       e_pix = 16'hF800;
                    1:       e_pix = int'(bars[(px * 8) / HA]);
                    2:       e_pix = px;
                    default: e_pix = (al % 256) * 256 + (px % 256);
                endcase
                e_data = e_href ? ((cl % 2 == 0) ? 8'(e_pix / 256) : 8'(e_pix % 256)) : 8'h00;
                chk("vsync", {31'd0, vsync}, {31'd0, e_vs});
                chk("href", {31'd0, href}, {31'd0, e_href});
                chk("data", {24'd0, data}, {24'd0, e_data});
                chk("busy", {31'd0, busy}, {31'd0, m_act});
                chk("frame_done", {31'd0, frame_done}, {31'd0, (m_act && m_t == FRAME - 1)});
                chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
                chk("vsync_href_excl", {31'd0, (vsync && href)}, 32'd0);
                if (!href) chk("data_zero_blank", {24'd0, data}, 32'd0);
                if (frame_done) done_cnt++;
                if (vsync && !prev_vs) rises.push_back(cyc);
                if (last_rst) begin
                    kb = 0; line_idx = 0; prev_href = 1'b0;
                end else begin
                    if (vsync) begin
                        line_idx = 0; kb = 0;
                    end
                    if (href) begin
                        if (line_idx < 4 && kb < 16) cap[line_idx][kb] = data;
                        kb++;
                    end else if (prev_href) begin
                        chk("bytes_per_line", kb, 32'd16);
                        line_idx++; kb = 0;
                    end
                    prev_href = href;
                end
                prev_vs = vsync;
            end
        end
    end

    int t_off = 0;
    task automatic goto_off(input int target);
        repeat (target - t_off) @(negedge clk);
        t_off = target;
    endtask

    logic [7:0] bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                   8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    initial begin
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);

        // Frame 1: pattern 3, absolute timing from the enable edge
        pattern_sel = 2'd3; enable = 1'b1; t_off = 0;
        goto_off(1);   chk("n+1 vsync", {31'd0, vsync}, 32'd1);
                       chk("n+1 busy", {31'd0, busy}, 32'd1);
        goto_off(20);  chk("n+20 vsync", {31'd0, vsync}, 32'd1);
        goto_off(21);  chk("n+21 vsync", {31'd0, vsync}, 32'd0);
        goto_off(40);  chk("n+40 href", {31'd0, href}, 32'd0);
        goto_off(41);  chk("n+41 href", {31'd0, href}, 32'd1);
        goto_off(130); pattern_sel = 2'd1;
        goto_off(140); chk("n+140 done", {31'd0, frame_done}, 32'd1);
                       chk("n+140 cnt", {16'd0, frame_cnt}, 32'd0);
        for (int k = 0; k < 16; k++)
            chk("pat3 line2", {24'd0, cap[2][k]}, (k % 2 == 0) ? 32'h02 : 32'(k / 2));
        goto_off(141); chk("n+141 cnt", {16'd0, frame_cnt}, 32'd1);
                       chk("n+141 vsync", {31'd0, vsync}, 32'd1);

        // Frame 2: colour bars
        goto_off(270); pattern_sel = 2'd2;
        goto_off(280); chk("f2 done", {31'd0, frame_done}, 32'd1);
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 16; k++)
                chk("pat1 bytes", {24'd0, cap[l][k]}, {24'd0, bar_bytes[k]});

        // Frame 3: x ramp, then pattern 0 latched for frame 4
        goto_off(410); pattern_sel = 2'd0;
        goto_off(421); chk("f3 cnt", {16'd0, frame_cnt}, 32'd3);
        chk("rise count", rises.size(), 32'd4);
        if (rises.size() >= 4)
            for (int i = 1; i < 4; i++) chk("vsync spacing", rises[i] - rises[i-1], 32'd140);

        // Frame 4: drop enable mid-active and change pattern
        goto_off(480); enable = 1'b0; pattern_sel = 2'd3;
        goto_off(560); chk("f4 done", {31'd0, frame_done}, 32'd1);
        chk("f4 old pattern hi", {24'd0, cap[3][0]}, 32'hF8);
        chk("f4 old pattern lo", {24'd0, cap[3][1]}, 32'h00);
        goto_off(561); chk("f4 busy off", {31'd0, busy}, 32'd0);
                       chk("f4 vsync off", {31'd0, vsync}, 32'd0);
                       chk("f4 cnt", {16'd0, frame_cnt}, 32'd4);
                       chk("done pulses", done_cnt, 32'd4);
        goto_off(600); chk("idle vsync", {31'd0, vsync}, 32'd0);

        // Reset mid-active, then restart
        enable = 1'b1; pattern_sel = 2'd2; t_off = 0;
        goto_off(50);  chk("pre-rst href", {31'd0, href}, 32'd1);
        reset = 1'b1;
        goto_off(51);  reset = 1'b0;
        chk("rst vsync", {31'd0, vsync}, 32'd0);
        chk("rst href", {31'd0, href}, 32'd0);
        chk("rst data", {24'd0, data}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, frame_done}, 32'd0);
        chk("rst cnt", {16'd0, frame_cnt}, 32'd0);
        goto_off(52);  chk("restart vsync", {31'd0, vsync}, 32'd1);
        goto_off(191); chk("restart done", {31'd0, frame_done}, 32'd1);
        goto_off(192); chk("restart cnt", {16'd0, frame_cnt}, 32'd1);

        // Random enable / pattern / occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pattern_sel = 2'($urandom);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
